// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter that merges icache and dcache line traffic onto one physical memory port.
// The winning request is latched so memory sees constant inputs for the whole transaction.
module cacheline_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              pmem_error,
    output logic              arb_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic              lastGrantD_q;
    logic              ownerD_q;
    logic              read_q, write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] iRdata_q, dRdata_q;
    logic              arbError_q;

    logic iReq, dReq, grantI, grantD, busy;

    assign iReq = i_read;
    assign dReq = d_read | d_write;
    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lastGrantD_q <= 1'b0;
            ownerD_q     <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            iRdata_q     <= '0;
            dRdata_q     <= '0;
            arbError_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Round-robin pointer only moves when both clients competed.
            if (grantI) begin
                ownerD_q <= 1'b0;
                addr_q   <= i_address;
                read_q   <= 1'b1;
                write_q  <= 1'b0;
                if (dReq) lastGrantD_q <= 1'b0;
            end
            if (grantD) begin
                ownerD_q <= 1'b1;
                addr_q   <= d_address;
                read_q   <= ~d_write;
                write_q  <= d_write;
                wdata_q  <= d_wdata;
                if (iReq) lastGrantD_q <= 1'b1;
            end
            if (busy) begin
                if (pmem_error) begin
                    arbError_q <= 1'b1;
                    read_q     <= 1'b0;
                    write_q    <= 1'b0;
                end else if (pmem_resp) begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (state_q == BUSY_D) dRdata_q <= pmem_rdata;
                    else iRdata_q <= pmem_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grantI  = 1'b0;
        grantD  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iReq && dReq) begin
                    if (lastGrantD_q) grantI = 1'b1;
                    else grantD = 1'b1;
                end else if (dReq) begin
                    grantD = 1'b1;
                end else if (iReq) begin
                    grantI = 1'b1;
                end
                if (grantI) state_d = BUSY_I;
                else if (grantD) state_d = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (pmem_error) state_d = IDLE;
                else if (pmem_resp) state_d = RECOVER;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RECOVER doubles as memory's post-response idle cycle.
    always_comb begin
        i_resp       = (state_q == RECOVER) && !ownerD_q;
        d_resp       = (state_q == RECOVER) && ownerD_q;
        i_rdata      = iRdata_q;
        d_rdata      = dRdata_q;
        pmem_read    = read_q;
        pmem_write   = write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        arb_error    = arbError_q;
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: behavioural memory responder plus a
// transaction-level reference model of round-robin order and line contents.
module tb_cacheline_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_address, d_address, pmem_address;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
    logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp, pmem_error, arb_error;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] memLines [logic [AW-1:0]];
    logic [LW-1:0] refMem   [logic [AW-1:0]];
    int            memLatency = 4;
    int            errorAt = 3;
    bit            injectError = 1'b0;
    int            stableViolations = 0;
    int            gapViolations = 0;
    int            txnCount = 0;
    logic [AW-1:0] lastTxnAddr = '0;
    logic          lastTxnWrite = 1'b0;

    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_error(pmem_error), .arb_error(arb_error)
    );

    function automatic logic [LW-1:0] defaultLine(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    function automatic logic [LW-1:0] refLookup(input logic [AW-1:0] a);
        return refMem.exists(a) ? refMem[a] : defaultLine(a);
    endfunction

    // Memory responder: counts latency, optionally injects an error, and tracks
    // input stability and the idle gap between transactions.
    initial begin
        bit            busy = 1'b0;
        int            cnt = 0;
        int            idleCnt = 10;
        logic          snapR = 1'b0, snapW = 1'b0;
        logic [AW-1:0] snapA = '0;
        logic [LW-1:0] snapWd = '0;
        pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            pmem_error = 1'b0;
            if (rst) begin
                busy = 1'b0; idleCnt = 10;
            end else if (!busy) begin
                if (pmem_read || pmem_write) begin
                    if (idleCnt < 2) gapViolations++;
                    busy = 1'b1; cnt = 1; txnCount++;
                    snapR = pmem_read; snapW = pmem_write; snapA = pmem_address; snapWd = pmem_wdata;
                    lastTxnAddr = pmem_address; lastTxnWrite = pmem_write;
                end else begin
                    idleCnt++;
                end
            end else begin
                if (pmem_read !== snapR || pmem_write !== snapW || pmem_address !== snapA ||
                    (snapW && pmem_wdata !== snapWd)) stableViolations++;
                if (injectError && cnt == errorAt) begin
                    pmem_error = 1'b1; injectError = 1'b0; busy = 1'b0; idleCnt = 10;
                end else if (cnt >= memLatency) begin
                    if (snapW) memLines[snapA] = snapWd;
                    pmem_rdata = memLines.exists(snapA) ? memLines[snapA] : defaultLine(snapA);
                    pmem_resp = 1'b1; busy = 1'b0; idleCnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one round of client requests, holding each until its resp, and
    // reports completion order, cycle of each resp and returned lines.
    task automatic applyStimulus(input bit doI, input bit doD, input logic [AW-1:0] ia,
                                 input logic [AW-1:0] da, input bit dr, input bit dw,
                                 input logic [LW-1:0] wd, input int changeAt,
                                 output int firstWho, output int iCyc, output int dCyc,
                                 output logic [LW-1:0] iData, output logic [LW-1:0] dData,
                                 output int bothResp, output int extraResp,
                                 output int busyAtResp, output bit timedOut);
        bit iPend, dPend;
        int cyc;
        firstWho = -1; iCyc = 0; dCyc = 0; iData = '0; dData = '0;
        bothResp = 0; extraResp = 0; busyAtResp = 0;
        @(negedge clk);
        i_read = doI; i_address = ia;
        d_read = dr & doD; d_write = dw & doD; d_address = da; d_wdata = wd;
        iPend = doI; dPend = doD; cyc = 0;
        while ((iPend || dPend) && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == changeAt) begin
                d_address = 32'h0000_0200; d_wdata = ~wd;
            end
            if (i_resp && d_resp) bothResp++;
            if ((i_resp || d_resp) && (pmem_read || pmem_write)) busyAtResp++;
            if (i_resp) begin
                if (!iPend) extraResp++;
                else begin
                    iPend = 1'b0; i_read = 1'b0; iData = i_rdata; iCyc = cyc;
                    if (firstWho < 0) firstWho = 0;
                end
            end
            if (d_resp) begin
                if (!dPend) extraResp++;
                else begin
                    dPend = 1'b0; d_read = 1'b0; d_write = 1'b0; dData = d_rdata; dCyc = cyc;
                    if (firstWho < 0) firstWho = 1;
                end
            end
        end
        timedOut = iPend || dPend;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (i_resp || d_resp) extraResp++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pmem_req: got %b expected 00", {pmem_read, pmem_write}); end
        checks++; if ({pmem_address, pmem_wdata} !== '0) begin errors++; $display("[TB] FAIL reset_pmem_bus: got %h/%h expected 0", pmem_address, pmem_wdata); end
        checks++; if ({i_resp, d_resp, arb_error} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {i_resp, d_resp, arb_error}); end
        checks++; if ({i_rdata, d_rdata} !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", i_rdata, d_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_icache_read();
        int fw, ic, dc, br, er, bar, t0, sv0; bit to; logic [LW-1:0] id, dd;
        memLines[32'h40] = {32{8'hA5}};
        memLatency = 25; t0 = txnCount; sv0 = stableViolations;
        applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, 0, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL icache_timeout: got %0d expected 0", to); end
        checks++; if (id !== {32{8'hA5}}) begin errors++; $display("[TB] FAIL icache_data: got %h expected %h", id, {32{8'hA5}}); end
        checks++; if (ic !== 27) begin errors++; $display("[TB] FAIL icache_latency: got %0d expected 27", ic); end
        checks++; if (er !== 0 || dc !== 0) begin errors++; $display("[TB] FAIL icache_stray_resp: got extra=%0d dcyc=%0d expected 0/0", er, dc); end
        checks++; if (lastTxnAddr !== 32'h40 || lastTxnWrite !== 1'b0) begin errors++; $display("[TB] FAIL icache_pmem_req: got addr %h write %b expected 40/0", lastTxnAddr, lastTxnWrite); end
        checks++; if (txnCount - t0 !== 1 || stableViolations !== sv0) begin errors++; $display("[TB] FAIL icache_pmem_stable: got txns %0d violations %0d expected 1/0", txnCount - t0, stableViolations - sv0); end
    endtask

    task automatic test_dcache_write();
        int fw, ic, dc, br, er, bar, sv0; bit to; logic [LW-1:0] id, dd, wd;
        wd = {16{16'h1234}};
        memLatency = 6; sv0 = stableViolations;
        applyStimulus(0, 1, '0, 32'h100, 0, 1, wd, 0, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (to !== 1'b0 || dc !== 8) begin errors++; $display("[TB] FAIL dwrite_latency: got timeout %0d cyc %0d expected 0/8", to, dc); end
        checks++; if (dd !== wd) begin errors++; $display("[TB] FAIL dwrite_rdata: got %h expected %h", dd, wd); end
        checks++; if (!memLines.exists(32'h100) || memLines[32'h100] !== wd || lastTxnWrite !== 1'b1) begin errors++; $display("[TB] FAIL dwrite_mem: write %b expected line %h", lastTxnWrite, wd); end
        checks++; if (bar !== 0 || er !== 0 || ic !== 0) begin errors++; $display("[TB] FAIL dwrite_resp: got busyAtResp %0d extra %0d icyc %0d expected 0/0/0", bar, er, ic); end
        checks++; if (stableViolations !== sv0) begin errors++; $display("[TB] FAIL dwrite_stable: got %0d expected 0", stableViolations - sv0); end
    endtask

    task automatic test_tie_alternation();
        int fw, ic, dc, br, er, bar; bit to; logic [LW-1:0] id, dd;
        int expFirst [3] = '{1, 0, 1};
        doReset();
        memLatency = 3;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1, 1, 32'h40, 32'h100, 1, 0, '0, 0, fw, ic, dc, id, dd, br, er, bar, to);
            checks++; if (to !== 1'b0 || fw !== expFirst[r]) begin errors++; $display("[TB] FAIL tie_order_%0d: got first %0d timeout %0d expected %0d", r, fw, to, expFirst[r]); end
            checks++; if (br !== 0 || er !== 0) begin errors++; $display("[TB] FAIL tie_resp_%0d: got both %0d extra %0d expected 0/0", r, br, er); end
        end
    endtask

    task automatic test_addr_change();
        int fw, ic, dc, br, er, bar, sv0; bit to; logic [LW-1:0] id, dd, wd;
        wd = {8{32'hCAFE_F00D}};
        memLatency = 10; sv0 = stableViolations;
        applyStimulus(0, 1, '0, 32'h100, 0, 1, wd, 5, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (stableViolations !== sv0) begin errors++; $display("[TB] FAIL addrchg_stable: got %0d violations expected 0", stableViolations - sv0); end
        checks++; if (lastTxnAddr !== 32'h100 || memLines.exists(32'h200)) begin errors++; $display("[TB] FAIL addrchg_addr: got %h expected 100", lastTxnAddr); end
        checks++; if (to !== 1'b0 || dd !== wd) begin errors++; $display("[TB] FAIL addrchg_rdata: got %h expected %h", dd, wd); end
    endtask

    task automatic test_error_retry();
        int fw, ic, dc, br, er, bar, t0; bit to; logic [LW-1:0] id, dd;
        memLatency = 6; errorAt = 3; injectError = 1'b1; t0 = txnCount;
        applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, 0, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (to !== 1'b0 || id !== {32{8'hA5}}) begin errors++; $display("[TB] FAIL err_retry_data: got %h timeout %0d expected A5 line", id, to); end
        checks++; if (ic !== 13) begin errors++; $display("[TB] FAIL err_retry_latency: got %0d expected 13", ic); end
        checks++; if (txnCount - t0 !== 2) begin errors++; $display("[TB] FAIL err_retry_txns: got %0d expected 2", txnCount - t0); end
        checks++; if (arb_error !== 1'b1) begin errors++; $display("[TB] FAIL err_flag: got %b expected 1", arb_error); end
        applyStimulus(0, 1, '0, 32'h100, 1, 0, '0, 0, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (arb_error !== 1'b1 || to !== 1'b0) begin errors++; $display("[TB] FAIL err_sticky: got %b timeout %0d expected 1/0", arb_error, to); end
    endtask

    task automatic test_reset_midbusy();
        int fw, ic, dc, br, er, bar; bit to; logic [LW-1:0] id, dd;
        memLatency = 20;
        @(negedge clk);
        d_read = 1'b1; d_write = 1'b0; d_address = 32'h300;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({pmem_read, pmem_write, d_resp, arb_error} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0000", {pmem_read, pmem_write, d_resp, arb_error}); end
        rst = 1'b0; d_read = 1'b0;
        memLatency = 4;
        applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, 0, fw, ic, dc, id, dd, br, er, bar, to);
        checks++; if (to !== 1'b0 || ic !== 6 || id !== {32{8'hA5}} || er !== 0) begin errors++; $display("[TB] FAIL rst_fresh_read: got cyc %0d data %h extra %0d expected 6/A5/0", ic, id, er); end
    endtask

    task automatic test_random();
        int fw, ic, dc, br, er, bar, pat, op, lat, expFirst, firstCyc; bit to, doI, doD;
        logic [AW-1:0] ia, da; logic [LW-1:0] id, dd, wd, expI, expD;
        bit refLastD;
        doReset();
        refLastD = 1'b0;
        for (int r = 0; r < 30; r++) begin
            pat = $urandom_range(1, 3); op = $urandom_range(0, 2); lat = $urandom_range(1, 8);
            doI = (pat != 2); doD = (pat != 1);
            ia = 32'h1000 + (32'($urandom_range(0, 7)) << 5);
            da = 32'h1000 + (32'($urandom_range(0, 7)) << 5);
            for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
            memLatency = lat;
            if (doI && doD) begin
                expFirst = refLastD ? 0 : 1;
                refLastD = (expFirst == 1);
            end else begin
                expFirst = doI ? 0 : 1;
            end
            expI = '0; expD = '0;
            for (int s = 0; s < 2; s++) begin
                if ((s == 0) == (expFirst == 0)) begin
                    if (doI) expI = refLookup(ia);
                end else if (doD) begin
                    if (op != 0) begin refMem[da] = wd; expD = wd; end
                    else expD = refLookup(da);
                end
            end
            applyStimulus(doI, doD, ia, da, (op != 1), (op != 0), wd, 0, fw, ic, dc, id, dd, br, er, bar, to);
            firstCyc = (fw == 0) ? ic : dc;
            checks++; if (to !== 1'b0 || fw !== expFirst) begin errors++; $display("[TB] FAIL rand_order_%0d: got first %0d timeout %0d expected %0d", r, fw, to, expFirst); end
            checks++; if (firstCyc !== lat + 2) begin errors++; $display("[TB] FAIL rand_latency_%0d: got %0d expected %0d", r, firstCyc, lat + 2); end
            checks++; if (id !== expI || dd !== expD) begin errors++; $display("[TB] FAIL rand_data_%0d: got %h/%h expected %h/%h", r, id, dd, expI, expD); end
            checks++; if (br !== 0 || er !== 0 || bar !== 0) begin errors++; $display("[TB] FAIL rand_resp_%0d: got both %0d extra %0d busy %0d expected 0/0/0", r, br, er, bar); end
        end
        checks++; if (gapViolations !== 0 || arb_error !== 1'b0) begin errors++; $display("[TB] FAIL rand_gap: got gaps %0d arb_error %b expected 0/0", gapViolations, arb_error); end
    endtask

    initial begin
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_tie_alternation();
        test_addr_change();
        test_error_retry();
        test_reset_midbusy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Arbitrates the instruction cache and data cache line-fill/writeback ports onto the single 256-bit physical memory port.
- Latches the granted request and holds pmem_* outputs constant for the whole transaction. Physical memory flags any mid-transaction input change as an error.
- Returns line data and a one-cycle resp to the granted client only.
- Sits between the L1 caches (upstream) and physical memory (downstream).

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  icache line read request; held until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line read request; held until d_resp.
- d_write  in  1  dcache line write request; held until d_resp.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion, one cycle.
- pmem_error  in  1  memory protocol error.
- arb_error  out  1  sticky error flag.

Behaviour:
- Reset (rst high at posedge): state=IDLE, last_grant=I (so D wins the first tie), all outputs 0, arb_error=0. Reset mid-transaction drops pmem_read/pmem_write the following cycle. No client resp is generated.
- States: IDLE, BUSY_I, BUSY_D, RECOVER.
- IDLE: requests are sampled only in this state.
  - Only I pending -> BUSY_I.
  - Only D pending (d_read|d_write) -> BUSY_D.
  - Both pending: grant the client not equal to last_grant (round-robin). Update last_grant.
  - On grant, latch address, op, and wdata into internal registers. pmem_* are driven from these registers in the next cycle.
- BUSY_x: pmem_read/pmem_write/pmem_address/pmem_wdata stay constant regardless of client input changes.
  - On pmem_resp: capture pmem_rdata into the granted client's rdata register, deassert pmem_read/pmem_write at the next edge, and go to RECOVER.
- RECOVER: granted client's resp=1 for exactly this cycle; its rdata is valid this cycle. Next state is IDLE.
  - This cycle also covers memory's post-response recovery cycle, so a new request cannot land on memory before memory is back in idle.
- Client latency: from IDLE grant to resp = memory latency + 2 cycles. Gap between back-to-back pmem transactions is at least 2 cycles.
- rdata registers hold their last value until overwritten.
- d_read and d_write both high is treated as a write. For a write, d_rdata receives pmem_rdata, the post-write line.
- pmem_error high in BUSY_x:
  - Set arb_error; it clears only on rst.
  - Drop pmem request and return to IDLE with no client resp.
  - A client still requesting is re-arbitrated under normal round-robin (retry).
- Client deasserts its request mid-transaction: ignored; the transaction completes and resp is still pulsed.
- i_resp and d_resp are never high in the same cycle.

Test Plan:
- Single icache read, addr 0x0000_0040, memory returns 256'hA5…A5 after 25 cycles -> pmem_read=1 with address 0x40 held throughout; i_resp one cycle, i_rdata=A5…A5; d_resp stays 0.
- Single dcache write, addr 0x100, wdata 256'h1234… -> pmem_write=1 with stable wdata; d_resp pulses once; pmem_write low before d_resp.
- i_read and d_read asserted same cycle out of reset -> D served first, then I. A second simultaneous pair -> I first, then D (alternation).
- Granted client changes d_address to 0x200 mid-BUSY -> pmem_address stays at the latched 0x100; no pmem_error.
- Inject pmem_error during BUSY_I with i_read held -> arb_error=1 and sticky; no i_resp; request reissued and then completes with i_resp.
- Assert rst during BUSY_D -> next cycle pmem_read/pmem_write=0, d_resp=0, state IDLE; a fresh i_read afterwards completes normally.
